// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode map of the downstream ALU
// and the FSM state encoding.
package alu_arbiter_pkg;

  localparam logic [3:0] OP_SUMA  = 4'd0;
  localparam logic [3:0] OP_RESTA = 4'd1;
  localparam logic [3:0] OP_MULT  = 4'd2;
  localparam logic [3:0] OP_MAYOR = 4'd3;
  localparam logic [3:0] OP_MENOR = 4'd4;
  localparam logic [3:0] OP_IGUAL = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_IZQ   = 4'd9;
  localparam logic [3:0] OP_DER   = 4'd10;
  localparam logic [3:0] OP_MAX   = 4'd10;

  localparam int FLAGS_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin pick: first valid requester strictly after ptr, wrapping,
// so ptr itself has the lowest priority.
module alu_arbiter_rr #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the nearest valid index wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int off = N; off >= 1; off--) begin
      idx = IW'((int'(ptr) + off) % N);
      if (valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant,
// registered operands in front of the ALU, registered result/flags behind it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*OP_W-1:0]     req_op,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [2*DATA_W-1:0]         rsp_result,
  output logic [FLAGS_W-1:0]          rsp_flags,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [OP_W-1:0]             alu_sel,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  input  logic [2*DATA_W-1:0]         alu_c,
  input  logic                        alu_carry,
  input  logic                        alu_overflow,
  input  logic                        alu_negativo,
  input  logic                        alu_cero
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0]   PTR_RST  = IW'(NUM_REQ - 1);
  localparam logic [OP_W-1:0] OP_LIMIT = OP_W'(OP_MAX);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  req_t [NUM_REQ-1:0] req;
  arb_state_e         state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic               gnt_vld;
  logic [IW-1:0]      gnt_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req[g] = {req_op[g*OP_W +: OP_W], req_a[g*DATA_W +: DATA_W],
                     req_b[g*DATA_W +: DATA_W]};
  end

  alu_arbiter_rr #(.N(NUM_REQ), .IW(IW)) u_rr (
    .valid   (req_valid),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Grant is offered only while idle; the granted requester transfers on the same edge.
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= PTR_RST;
      owner      <= '0;
      alu_sel    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            alu_sel <= req[gnt_idx].op;
            alu_a   <= req[gnt_idx].a;
            alu_b   <= req[gnt_idx].b;
            owner   <= gnt_idx;
            ptr     <= gnt_idx;
            busy    <= 1'b1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Opcodes beyond the ALU's map give a clean zero result with an error flag.
          if (alu_sel > OP_LIMIT) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_c;
            rsp_flags  <= {alu_carry, alu_overflow, alu_negativo, alu_cero};
            rsp_err    <= 1'b0;
          end
          rsp_valid <= NUM_REQ'(1) << owner;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model on its ALU ports.
module tb_alu_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int OW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*OW-1:0]   req_op;
  logic [N*DW-1:0]   req_a, req_b;
  logic [2*DW-1:0]   rsp_result;
  logic [3:0]        rsp_flags;
  logic              rsp_err, busy;
  logic [OW-1:0]     alu_sel;
  logic [DW-1:0]     alu_a, alu_b;
  logic [2*DW-1:0]   alu_c;
  logic              alu_carry, alu_overflow, alu_negativo, alu_cero;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .alu_sel      (alu_sel),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_c        (alu_c),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_negativo (alu_negativo),
    .alu_cero     (alu_cero)
  );

  // ALU model; unmapped opcodes drive a nonzero pattern so forcing to zero is visible.
  logic [8:0]  sum9;
  logic [15:0] diff;
  always_comb begin
    sum9         = {1'b0, alu_a} + {1'b0, alu_b};
    diff         = {8'h00, alu_a} - {8'h00, alu_b};
    alu_c        = 16'hDEAD;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_sel)
      4'd0: begin
        alu_c        = {7'd0, sum9};
        alu_carry    = sum9[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
      end
      4'd1: begin
        alu_c        = diff;
        alu_overflow = (alu_a[7] != alu_b[7]) && (diff[7] != alu_a[7]);
      end
      4'd2:  alu_c = {8'h00, alu_a} * {8'h00, alu_b};
      4'd3:  alu_c = {15'd0, alu_a > alu_b};
      4'd4:  alu_c = {15'd0, alu_a < alu_b};
      4'd5:  alu_c = {15'd0, alu_a == alu_b};
      4'd6:  alu_c = {8'h00, alu_a & alu_b};
      4'd7:  alu_c = {8'h00, alu_a | alu_b};
      4'd8:  alu_c = {8'h00, alu_a ^ alu_b};
      4'd9:  alu_c = {8'h00, alu_a} << alu_b[3:0];
      4'd10: alu_c = {8'h00, alu_a} >> alu_b[3:0];
      default: alu_c = 16'hDEAD;
    endcase
    alu_negativo = alu_c[15];
    alu_cero     = (alu_c == 16'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    req_valid[i]         = 1'b1;
    req_op[i*OW +: OW]   = op;
    req_a[i*DW +: DW]    = a;
    req_b[i*DW +: DW]    = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Entered at a negedge in IDLE with requests already driven; leaves at a negedge in IDLE.
  task automatic serve(input int i, input logic [15:0] res, input logic [3:0] fl,
                       input logic err, input string tag);
    #1 chk({tag, "_ready"}, 32'(req_ready), 32'(1) << i);
    @(negedge clk);
    req_valid[i] = 1'b0;
    chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
    chk({tag, "_exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1) << i);
    chk({tag, "_result"}, 32'(rsp_result), 32'(res));
    chk({tag, "_flags"}, 32'(rsp_flags), 32'(fl));
    chk({tag, "_err"}, 32'(rsp_err), 32'(err));
    rsp_ready = '1;
    @(negedge clk);
    rsp_ready = '0;
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    req_op = '0;
    req_a  = '0;
    req_b  = '0;
    do_reset();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // 1: single add
    set_req(0, 4'd0, 8'd50, 8'd30);
    serve(0, 16'd80, 4'b0000, 1'b0, "t1_suma");
    chk("t1_alu_a_hold", 32'(alu_a), 32'd50);

    // 2: simultaneous requests alternate after reset
    do_reset();
    set_req(0, 4'd2, 8'd15, 8'd10);
    set_req(1, 4'd8, 8'hAA, 8'hCC);
    serve(0, 16'd150, 4'b0000, 1'b0, "t2_mult_a");
    serve(1, 16'h0066, 4'b0000, 1'b0, "t2_xor_a");
    set_req(0, 4'd2, 8'd15, 8'd10);
    set_req(1, 4'd8, 8'hAA, 8'hCC);
    serve(0, 16'd150, 4'b0000, 1'b0, "t2_mult_b");
    serve(1, 16'h0066, 4'b0000, 1'b0, "t2_xor_b");

    // 3: backpressure on req0 with req1 waiting; 200+100 carries out
    set_req(0, 4'd0, 8'd200, 8'd100);
    set_req(1, 4'd6, 8'hF0, 8'h3C);
    #1 chk("t3_ready0", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rsp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t3_hold_result", 32'(rsp_result), 32'h012C);
      chk("t3_hold_flags", 32'(rsp_flags), 32'b1000);
      chk("t3_hold_busy", 32'(busy), 32'd1);
      chk("t3_hold_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = '0;
    #1 chk("t3_release_valid", 32'(rsp_valid), 32'd0);
    chk("t3_release_busy", 32'(busy), 32'd0);
    serve(1, 16'h0030, 4'b0000, 1'b0, "t3_and");

    // 4: illegal opcode
    set_req(1, 4'b1100, 8'd5, 8'd5);
    serve(1, 16'd0, 4'b0000, 1'b1, "t4_illegal");

    // 5: subtraction flags
    set_req(0, 4'd1, 8'd1, 8'd1);
    serve(0, 16'd0, 4'b0001, 1'b0, "t5_resta_zero");
    set_req(0, 4'd1, 8'd40, 8'd100);
    serve(0, 16'hFFC4, 4'b0010, 1'b0, "t5_resta_neg");

    // 6: reset while in EXEC
    set_req(0, 4'd0, 8'd50, 8'd30);
    #1 chk("t6_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_result", 32'(rsp_result), 32'd0);
    chk("t6_rst_flags", 32'(rsp_flags), 32'd0);
    chk("t6_rst_err", 32'(rsp_err), 32'd0);
    chk("t6_rst_alu", {16'd0, alu_sel, 4'd0, alu_a}, 32'd0);
    chk("t6_rst_alu_b", 32'(alu_b), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    end
    set_req(0, 4'd7, 8'h0F, 8'hF0);
    set_req(1, 4'd9, 8'h81, 8'd4);
    serve(0, 16'h00FF, 4'b0000, 1'b0, "t6_or");
    serve(1, 16'h0810, 4'b0000, 1'b0, "t6_izq");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
